// File: rtl/reg_file.sv
// 32 x 32 general-purpose register file: two combinational read ports,
// one synchronous write port, and a registered copy of the last written value.
module reg_file #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned NREGS  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] regAddr1,
  input  logic [ADDR_W-1:0] regAddr2,
  input  logic [ADDR_W-1:0] writeAddr,
  input  logic [DATA_W-1:0] writeData,
  input  logic              regWrite,
  output logic [DATA_W-1:0] regData1,
  output logic [DATA_W-1:0] regData2,
  output logic [DATA_W-1:0] resOut
);

  logic [DATA_W-1:0] regs [NREGS];

  // r0 is never written, but resOut still records the attempted value
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
      resOut <= '0;
    end else if (regWrite) begin
      if (writeAddr != '0) begin
        regs[writeAddr] <= writeData;
      end
      resOut <= writeData;
    end
  end

  always_comb begin
    regData1 = (regAddr1 == '0) ? '0 : regs[regAddr1];
    regData2 = (regAddr2 == '0) ? '0 : regs[regAddr2];
  end

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed scenarios plus randomized
// traffic checked against an array-based reference model.
module tb_reg_file;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  regAddr1, regAddr2, writeAddr;
  logic [31:0] writeData;
  logic        regWrite;
  logic [31:0] regData1, regData2, resOut;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  logic [31:0] model [32];
  logic [31:0] model_res;

  reg_file #(.DATA_W(32), .ADDR_W(5), .NREGS(32)) dut (
    .clk(clk), .rst(rst),
    .regAddr1(regAddr1), .regAddr2(regAddr2),
    .writeAddr(writeAddr), .writeData(writeData), .regWrite(regWrite),
    .regData1(regData1), .regData2(regData2), .resOut(resOut)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model_read(input logic [4:0] a);
    return (a == 5'd0) ? 32'd0 : model[a];
  endfunction

  // Update the model from the currently applied inputs, then clock the DUT.
  task automatic tick();
    if (rst) begin
      for (int i = 0; i < 32; i++) model[i] = 32'd0;
      model_res = 32'd0;
    end else if (regWrite) begin
      if (writeAddr != 5'd0) model[writeAddr] = writeData;
      model_res = writeData;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; regWrite = 1'b1; writeAddr = 5'd3; writeData = 32'h1234_5678;
    regAddr1 = '0; regAddr2 = '0;
    tick(); tick();
    for (int a = 0; a < 32; a++) begin
      regAddr1 = a[4:0]; regAddr2 = 5'(31 - a);
      #1;
      n_checks++;
      if (regData1 !== 32'd0) begin
        n_fail++; $display("FAIL reset_rd1 addr=%0d got=%h exp=%h", a, regData1, 32'd0);
      end
      n_checks++;
      if (regData2 !== 32'd0) begin
        n_fail++; $display("FAIL reset_rd2 addr=%0d got=%h exp=%h", 31 - a, regData2, 32'd0);
      end
    end
    n_checks++;
    if (resOut !== 32'd0) begin
      n_fail++; $display("FAIL reset_resout got=%h exp=%h", resOut, 32'd0);
    end
    rst = 1'b0; regWrite = 1'b0;
  endtask

  task automatic test_write_readback();
    regWrite = 1'b1; writeAddr = 5'd5; writeData = 32'd64;
    regAddr1 = 5'd5; regAddr2 = 5'd31;
    #1;
    n_checks++;
    if (regData1 !== 32'd0) begin
      n_fail++; $display("FAIL wr_no_bypass got=%h exp=%h", regData1, 32'd0);
    end
    tick();
    regWrite = 1'b0;
    n_checks++;
    if (regData1 !== 32'd64) begin
      n_fail++; $display("FAIL wr_readback got=%h exp=%h", regData1, 32'd64);
    end
    n_checks++;
    if (regData2 !== 32'd0) begin
      n_fail++; $display("FAIL wr_other_reg got=%h exp=%h", regData2, 32'd0);
    end
    n_checks++;
    if (resOut !== 32'd64) begin
      n_fail++; $display("FAIL wr_resout got=%h exp=%h", resOut, 32'd64);
    end
  endtask

  task automatic test_second_write();
    regWrite = 1'b1; writeAddr = 5'd12; writeData = 32'd15; regAddr1 = 5'd12;
    tick();
    regWrite = 1'b0;
    n_checks++;
    if (regData1 !== 32'd15) begin
      n_fail++; $display("FAIL wr2_readback got=%h exp=%h", regData1, 32'd15);
    end
    n_checks++;
    if (resOut !== 32'd15) begin
      n_fail++; $display("FAIL wr2_resout got=%h exp=%h", resOut, 32'd15);
    end
    regAddr2 = 5'd5;
    #1;
    n_checks++;
    if (regData2 !== 32'd64) begin
      n_fail++; $display("FAIL wr2_r5_kept got=%h exp=%h", regData2, 32'd64);
    end
  endtask

  task automatic test_write_disable();
    regWrite = 1'b0; writeAddr = 5'd5; writeData = 32'hDEAD_BEEF; regAddr1 = 5'd5;
    for (int i = 0; i < 4; i++) tick();
    n_checks++;
    if (regData1 !== 32'd64) begin
      n_fail++; $display("FAIL wdis_r5 got=%h exp=%h", regData1, 32'd64);
    end
    n_checks++;
    if (resOut !== 32'd15) begin
      n_fail++; $display("FAIL wdis_resout got=%h exp=%h", resOut, 32'd15);
    end
  endtask

  task automatic test_r0_priority();
    regWrite = 1'b1; writeAddr = 5'd0; writeData = 32'hFFFF_FFFF; regAddr1 = 5'd0;
    tick();
    regWrite = 1'b0;
    n_checks++;
    if (regData1 !== 32'd0) begin
      n_fail++; $display("FAIL r0_zero got=%h exp=%h", regData1, 32'd0);
    end
    n_checks++;
    if (resOut !== 32'hFFFF_FFFF) begin
      n_fail++; $display("FAIL r0_resout got=%h exp=%h", resOut, 32'hFFFF_FFFF);
    end
    rst = 1'b1; regWrite = 1'b1; writeAddr = 5'd7; writeData = 32'h0BAD_F00D;
    tick();
    rst = 1'b0; regWrite = 1'b0;
    regAddr1 = 5'd7; regAddr2 = 5'd5;
    #1;
    n_checks++;
    if (regData1 !== 32'd0) begin
      n_fail++; $display("FAIL prio_r7 got=%h exp=%h", regData1, 32'd0);
    end
    n_checks++;
    if (regData2 !== 32'd0) begin
      n_fail++; $display("FAIL prio_r5 got=%h exp=%h", regData2, 32'd0);
    end
    regAddr1 = 5'd12;
    #1;
    n_checks++;
    if (regData1 !== 32'd0) begin
      n_fail++; $display("FAIL prio_r12 got=%h exp=%h", regData1, 32'd0);
    end
    n_checks++;
    if (resOut !== 32'd0) begin
      n_fail++; $display("FAIL prio_resout got=%h exp=%h", resOut, 32'd0);
    end
  endtask

  task automatic test_dual_port();
    regWrite = 1'b1; writeAddr = 5'd31; writeData = 32'hA5A5_A5A5;
    regAddr1 = 5'd31; regAddr2 = 5'd31;
    tick();
    regWrite = 1'b0;
    n_checks++;
    if (regData1 !== 32'hA5A5_A5A5) begin
      n_fail++; $display("FAIL dual_rd1 got=%h exp=%h", regData1, 32'hA5A5_A5A5);
    end
    n_checks++;
    if (regData2 !== 32'hA5A5_A5A5) begin
      n_fail++; $display("FAIL dual_rd2 got=%h exp=%h", regData2, 32'hA5A5_A5A5);
    end
  endtask

  task automatic test_random();
    logic [31:0] e1, e2;
    for (int i = 0; i < 400; i++) begin
      rst       = ($urandom_range(0, 39) == 0);
      regWrite  = ($urandom_range(0, 3) != 0);
      writeAddr = 5'($urandom_range(0, 31));
      writeData = $urandom;
      regAddr1  = ($urandom_range(0, 2) == 0) ? writeAddr : 5'($urandom_range(0, 31));
      regAddr2  = 5'($urandom_range(0, 31));
      #1;
      e1 = model_read(regAddr1);
      e2 = model_read(regAddr2);
      n_checks++;
      if (regData1 !== e1) begin
        n_fail++; $display("FAIL rnd_pre_rd1 it=%0d addr=%0d got=%h exp=%h", i, regAddr1, regData1, e1);
      end
      n_checks++;
      if (regData2 !== e2) begin
        n_fail++; $display("FAIL rnd_pre_rd2 it=%0d addr=%0d got=%h exp=%h", i, regAddr2, regData2, e2);
      end
      tick();
      e1 = model_read(regAddr1);
      e2 = model_read(regAddr2);
      n_checks++;
      if (regData1 !== e1) begin
        n_fail++; $display("FAIL rnd_post_rd1 it=%0d addr=%0d got=%h exp=%h", i, regAddr1, regData1, e1);
      end
      n_checks++;
      if (regData2 !== e2) begin
        n_fail++; $display("FAIL rnd_post_rd2 it=%0d addr=%0d got=%h exp=%h", i, regAddr2, regData2, e2);
      end
      n_checks++;
      if (resOut !== model_res) begin
        n_fail++; $display("FAIL rnd_resout it=%0d got=%h exp=%h", i, resOut, model_res);
      end
    end
    rst = 1'b0; regWrite = 1'b0;
    for (int a = 0; a < 32; a++) begin
      regAddr1 = a[4:0];
      #1;
      e1 = model_read(regAddr1);
      n_checks++;
      if (regData1 !== e1) begin
        n_fail++; $display("FAIL rnd_sweep addr=%0d got=%h exp=%h", a, regData1, e1);
      end
    end
  endtask

  initial begin
    rst = 1'b1; regWrite = 1'b0; writeAddr = '0; writeData = '0;
    regAddr1 = '0; regAddr2 = '0;
    for (int i = 0; i < 32; i++) model[i] = 32'd0;
    model_res = 32'd0;
    #2;
    test_reset();
    test_write_readback();
    test_second_write();
    test_write_disable();
    test_r0_priority();
    test_dual_port();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
